// File: rtl/input_map_pkg.sv
// Shared definitions for the arcade input mapper: joystick bit layout,
// PS/2 set-2 scan codes per player, and the coin/start sequencer states.
package input_map_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_BTN0  = 4;
  localparam int START_OFS = 4;  // start index is START_OFS + NUM_BTN
  localparam int COIN_OFS  = 5;  // coin index is COIN_OFS + NUM_BTN
  localparam int JOY_IN_W  = 16;

  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  // Player 1: arrows (extended), Ctrl/Space/Alt/Shift, F1, 5
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_BTN0  = 8'h14;
  localparam logic [7:0] SC_P1_BTN1  = 8'h29;
  localparam logic [7:0] SC_P1_BTN2  = 8'h11;
  localparam logic [7:0] SC_P1_BTN3  = 8'h12;
  localparam logic [7:0] SC_P1_START = 8'h05;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E;

  // Player 2: R/D/F/G as up/left/down/right, A/S/Q/W, F2, 6
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_BTN0  = 8'h1C;
  localparam logic [7:0] SC_P2_BTN1  = 8'h1B;
  localparam logic [7:0] SC_P2_BTN2  = 8'h15;
  localparam logic [7:0] SC_P2_BTN3  = 8'h1D;
  localparam logic [7:0] SC_P2_START = 8'h06;
  localparam logic [7:0] SC_P2_COIN  = 8'h36;

  typedef enum logic [2:0] {
    CS_IDLE,
    CS_COIN,
    CS_GAP,
    CS_WAIT,
    CS_START
  } coin_state_e;

  typedef enum logic [3:0] {
    KF_NONE, KF_R, KF_L, KF_D, KF_U,
    KF_B0, KF_B1, KF_B2, KF_B3, KF_START, KF_COIN
  } key_func_e;

  typedef struct packed {
    logic      hit;
    logic      player;
    key_func_e func;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic [7:0] code, input logic ext);
    key_map_t m;
    case ({ext, code})
      {1'b1, SC_P1_RIGHT}: m = '{1'b1, 1'b0, KF_R};
      {1'b1, SC_P1_LEFT }: m = '{1'b1, 1'b0, KF_L};
      {1'b1, SC_P1_DOWN }: m = '{1'b1, 1'b0, KF_D};
      {1'b1, SC_P1_UP   }: m = '{1'b1, 1'b0, KF_U};
      {1'b0, SC_P1_BTN0 }: m = '{1'b1, 1'b0, KF_B0};
      {1'b0, SC_P1_BTN1 }: m = '{1'b1, 1'b0, KF_B1};
      {1'b0, SC_P1_BTN2 }: m = '{1'b1, 1'b0, KF_B2};
      {1'b0, SC_P1_BTN3 }: m = '{1'b1, 1'b0, KF_B3};
      {1'b0, SC_P1_START}: m = '{1'b1, 1'b0, KF_START};
      {1'b0, SC_P1_COIN }: m = '{1'b1, 1'b0, KF_COIN};
      {1'b0, SC_P2_RIGHT}: m = '{1'b1, 1'b1, KF_R};
      {1'b0, SC_P2_LEFT }: m = '{1'b1, 1'b1, KF_L};
      {1'b0, SC_P2_DOWN }: m = '{1'b1, 1'b1, KF_D};
      {1'b0, SC_P2_UP   }: m = '{1'b1, 1'b1, KF_U};
      {1'b0, SC_P2_BTN0 }: m = '{1'b1, 1'b1, KF_B0};
      {1'b0, SC_P2_BTN1 }: m = '{1'b1, 1'b1, KF_B1};
      {1'b0, SC_P2_BTN2 }: m = '{1'b1, 1'b1, KF_B2};
      {1'b0, SC_P2_BTN3 }: m = '{1'b1, 1'b1, KF_B3};
      {1'b0, SC_P2_START}: m = '{1'b1, 1'b1, KF_START};
      {1'b0, SC_P2_COIN }: m = '{1'b1, 1'b1, KF_COIN};
      default:             m = '{1'b0, 1'b0, KF_NONE};
    endcase
    return m;
  endfunction

  // Output bit index for a key function; -1 when the button does not exist.
  function automatic int key_idx(input key_func_e f, input int nbtn);
    int b;
    b = int'(f) - int'(KF_B0);
    case (f)
      KF_R:     return JOY_R;
      KF_L:     return JOY_L;
      KF_D:     return JOY_D;
      KF_U:     return JOY_U;
      KF_B0, KF_B1, KF_B2, KF_B3:
                return (b < nbtn) ? JOY_BTN0 + b : -1;
      KF_START: return START_OFS + nbtn;
      KF_COIN:  return COIN_OFS + nbtn;
      default:  return -1;
    endcase
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Input/output bundle between hps_io side signals and the input mapper.
interface arcade_input_mapper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BTN     = 2
);
  logic [64:0]                          ps2_key;
  logic [16*NUM_PLAYERS-1:0]            joy_in;
  logic                                 clr_keys;
  logic [NUM_PLAYERS-1:0]               autofire_en;
  logic                                 coinstart_mode;
  logic [(6+NUM_BTN)*NUM_PLAYERS-1:0]   joy_out;

  modport master (
    output ps2_key, joy_in, clr_keys, autofire_en, coinstart_mode,
    input  joy_out
  );

  modport slave (
    input  ps2_key, joy_in, clr_keys, autofire_en, coinstart_mode,
    output joy_out
  );
endinterface

// File: rtl/coin_start_seq.sv
// Per-player coin pulse generator with optional coin-then-start sequence.
//   state    | meaning
//   CS_IDLE  | waiting for a raw coin (or start, in coin-start mode) edge
//   CS_COIN  | coin output high for COIN_PULSE_CYC cycles
//   CS_GAP   | lockout of COIN_PULSE_CYC cycles, edges ignored
//   CS_WAIT  | START_DELAY_CYC cycles before the generated start
//   CS_START | start output high for COIN_PULSE_CYC cycles
module coin_start_seq
  import input_map_pkg::*;
#(
  parameter logic [23:0] COIN_PULSE_CYC  = 24'd3000000,
  parameter logic [23:0] START_DELAY_CYC = 24'd6000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  input  logic start_raw,
  input  logic coinstart_mode,
  output logic coin_out,
  output logic start_out
);

  coin_state_e state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        seq_q, seq_d;
  logic        mode_q, mode_d;
  logic        coin_prev_q, coin_prev_d;
  logic        start_prev_q, start_prev_d;
  logic        coin_rise, start_rise, eff_mode;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= CS_IDLE;
      cnt_q        <= '0;
      seq_q        <= 1'b0;
      mode_q       <= 1'b0;
      coin_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      mode_q       <= mode_d;
      coin_prev_q  <= coin_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == '0) ? '0 : cnt_q - 24'd1;
    seq_d        = seq_q;
    mode_d       = mode_q;
    coin_prev_d  = coin_raw;
    start_prev_d = start_raw;
    coin_rise    = coin_raw & ~coin_prev_q;
    start_rise   = start_raw & ~start_prev_q;
    eff_mode     = mode_q;
    coin_out     = 1'b0;
    start_out    = 1'b0;

    case (state_q)
      CS_IDLE: begin
        // The mode is only followed live while idle; a running sequence keeps its own copy.
        eff_mode = coinstart_mode;
        mode_d   = coinstart_mode;
        seq_d    = 1'b0;
        if (coin_rise || (start_rise && coinstart_mode)) begin
          state_d = CS_COIN;
          cnt_d   = COIN_PULSE_CYC - 24'd1;
          seq_d   = start_rise & coinstart_mode;
        end
      end
      CS_COIN: begin
        coin_out = 1'b1;
        if (cnt_q == '0) begin
          state_d = CS_GAP;
          cnt_d   = COIN_PULSE_CYC - 24'd1;
        end
      end
      CS_GAP: begin
        if (cnt_q == '0) begin
          if (seq_q) begin
            state_d = CS_WAIT;
            cnt_d   = START_DELAY_CYC - 24'd1;
          end else begin
            state_d = CS_IDLE;
          end
        end
      end
      CS_WAIT: begin
        if (cnt_q == '0) begin
          state_d = CS_START;
          cnt_d   = COIN_PULSE_CYC - 24'd1;
        end
      end
      CS_START: begin
        start_out = 1'b1;
        if (cnt_q == '0) begin
          state_d = CS_IDLE;
          seq_d   = 1'b0;
        end
      end
      default: state_d = CS_IDLE;
    endcase

    start_out = start_out | (start_raw & ~eff_mode);
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front end: PS/2 key decode merged with MiSTer joysticks,
// SOCD cleaning, autofire on button 0 and per-player coin/start sequencing.
module arcade_input_mapper
  import input_map_pkg::*;
#(
  parameter int          NUM_PLAYERS     = 2,
  parameter int          NUM_BTN         = 2,
  parameter logic [23:0] AUTOFIRE_HALF   = 24'd1500000,
  parameter logic [23:0] COIN_PULSE_CYC  = 24'd3000000,
  parameter logic [23:0] START_DELAY_CYC = 24'd6000000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  arcade_input_mapper_if.slave io
);

  localparam int W         = 6 + NUM_BTN;
  localparam int START_IDX = START_OFS + NUM_BTN;
  localparam int COIN_IDX  = COIN_OFS + NUM_BTN;
  localparam int OW        = W * NUM_PLAYERS;

  logic          ps2_tog_q, ps2_tog_d;
  logic [OW-1:0] key_q, key_d;
  logic [OW-1:0] joy_out_q, joy_out_d;
  logic [23:0]   af_cnt_q, af_cnt_d;
  logic          af_phase_q, af_phase_d;
  logic [OW-1:0] raw;
  logic [NUM_PLAYERS-1:0] coin_seq, start_seq;

  logic     ev, pressed, ext;
  key_map_t km;
  int       kidx;
  logic     unused_joy;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_tog_q  <= 1'b0;
      key_q      <= '0;
      joy_out_q  <= '0;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      ps2_tog_q  <= ps2_tog_d;
      key_q      <= key_d;
      joy_out_q  <= joy_out_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  // Key decode; the toggle copy keeps tracking during clr_keys so held-off events are lost.
  always_comb begin
    ps2_tog_d = io.ps2_key[64];
    ev        = io.ps2_key[64] != ps2_tog_q;
    pressed   = io.ps2_key[15:8] != PS2_REL;
    ext       = pressed ? (io.ps2_key[15:8] == PS2_EXT) : (io.ps2_key[23:16] == PS2_EXT);
    km        = key_lookup(io.ps2_key[7:0], ext);
    kidx      = key_idx(km.func, NUM_BTN);
    key_d     = key_q;
    if (io.clr_keys) begin
      key_d = '0;
    end else if (ev && (io.ps2_key[63:24] == '0) && km.hit) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int b = 0; b < W; b++) begin
          if ((int'(km.player) == p) && (kidx == b)) key_d[p*W+b] = pressed;
        end
      end
    end
  end

  always_comb begin
    af_cnt_d   = af_cnt_q + 24'd1;
    af_phase_d = af_phase_q;
    if (af_cnt_q >= AUTOFIRE_HALF - 24'd1) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign raw[p*W +: W] = key_q[p*W +: W] | io.joy_in[p*JOY_IN_W +: W];

    coin_start_seq #(
      .COIN_PULSE_CYC (COIN_PULSE_CYC),
      .START_DELAY_CYC(START_DELAY_CYC)
    ) u_seq (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .coin_raw      (raw[p*W+COIN_IDX]),
      .start_raw     (raw[p*W+START_IDX]),
      .coinstart_mode(io.coinstart_mode),
      .coin_out      (coin_seq[p]),
      .start_out     (start_seq[p])
    );
  end

  always_comb begin
    joy_out_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_out_d[p*W+JOY_R]    = raw[p*W+JOY_R] & ~raw[p*W+JOY_L];
      joy_out_d[p*W+JOY_L]    = raw[p*W+JOY_L] & ~raw[p*W+JOY_R];
      joy_out_d[p*W+JOY_D]    = raw[p*W+JOY_D] & ~raw[p*W+JOY_U];
      joy_out_d[p*W+JOY_U]    = raw[p*W+JOY_U] & ~raw[p*W+JOY_D];
      joy_out_d[p*W+JOY_BTN0] = raw[p*W+JOY_BTN0] & (~io.autofire_en[p] | af_phase_q);
      for (int b = 1; b < NUM_BTN; b++) begin
        joy_out_d[p*W+JOY_BTN0+b] = raw[p*W+JOY_BTN0+b];
      end
      joy_out_d[p*W+START_IDX] = start_seq[p];
      joy_out_d[p*W+COIN_IDX]  = coin_seq[p];
    end
  end

  always_comb begin
    unused_joy = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = W; b < JOY_IN_W; b++) unused_joy = unused_joy ^ io.joy_in[p*JOY_IN_W+b];
    end
  end

  assign io.joy_out = joy_out_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: joystick vector table plus
// sequences for PS/2 decode, autofire, coin pulse, coin-start, reset and clr_keys.
module tb_arcade_input_mapper;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  arcade_input_mapper_if #(.NUM_PLAYERS(2), .NUM_BTN(2)) io ();

  arcade_input_mapper #(
    .NUM_PLAYERS    (2),
    .NUM_BTN        (2),
    .AUTOFIRE_HALF  (24'd4),
    .COIN_PULSE_CYC (24'd8),
    .START_DELAY_CYC(24'd5)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .io     (io)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [31:0] joy;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  logic [44:0] ctr, str;
  int   ntrans, last_t, highs, rises, first_r, second_r, cnt;
  logic prev, seen0, found;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic [23:0] bytes);
    io.ps2_key = {~io.ps2_key[64], 40'h0, bytes};
  endtask

  // Counts high samples, rising edges and the first two rising positions.
  task automatic analyze(input logic [44:0] tr, input int n);
    logic p;
    highs = 0; rises = 0; first_r = -1; second_r = -1; p = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tr[i]) highs++;
      if (tr[i] && !p) begin
        rises++;
        if (first_r < 0) first_r = i;
        else if (second_r < 0) second_r = i;
      end
      p = tr[i];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0011, 16'h0011};
    vecs[1] = '{32'h0000_0013, 16'h0010};
    vecs[2] = '{32'h0000_000C, 16'h0000};
    vecs[3] = '{32'h0000_0024, 16'h0024};
    vecs[4] = '{32'h0000_0048, 16'h0048};
    vecs[5] = '{32'h0032_0000, 16'h3200};
    vecs[6] = '{32'h0003_0003, 16'h0000};
    vecs[7] = '{32'h0001_0002, 16'h0102};
    vecs[8] = '{32'h0000_FF00, 16'h0000};
    vecs[9] = '{32'h0000_0000, 16'h0000};

    io.ps2_key = '0; io.joy_in = '0; io.clr_keys = 1'b0;
    io.autofire_en = '0; io.coinstart_mode = 1'b0;

    cyc(2);
    check("reset_out", io.joy_out, 16'h0);
    reset = 1'b0;
    cyc(1);
    check("post_reset_out", io.joy_out, 16'h0);

    // joystick vectors, one clock latency
    for (int i = 0; i < 10; i++) begin
      io.joy_in = vecs[i].joy;
      cyc(1);
      check($sformatf("vec%0d", i), io.joy_out, vecs[i].exp);
    end
    io.joy_in = '0;
    cyc(2);

    // PS/2 decode
    send_key(24'h00E075);
    cyc(1);
    check("up_lat1", io.joy_out[3], 1'b0);
    cyc(1);
    check("up_press", io.joy_out[3], 1'b1);
    send_key(24'hE0F075);
    cyc(2);
    check("up_release", io.joy_out[3], 1'b0);
    io.ps2_key = {~io.ps2_key[64], 40'h1, 24'h00E075};
    cyc(2);
    check("upper_ignored", io.joy_out, 16'h0);
    send_key(24'h000075);
    cyc(2);
    check("nonext_75_ignored", io.joy_out, 16'h0);
    send_key(24'h00001C);
    cyc(2);
    check("p2_a_press", io.joy_out, 16'h1000);
    send_key(24'h00E06B);
    cyc(2);
    check("p1_left_key", io.joy_out, 16'h1002);
    io.joy_in[0] = 1'b1;
    cyc(1);
    check("socd_key_joy", io.joy_out, 16'h1000);
    io.joy_in[0] = 1'b0;
    cyc(1);
    check("socd_restore", io.joy_out, 16'h1002);
    send_key(24'h000015);
    cyc(2);
    check("absent_btn_ignored", io.joy_out, 16'h1002);
    send_key(24'h00F01C);
    cyc(1);
    send_key(24'hE0F06B);
    cyc(2);
    check("keys_released", io.joy_out, 16'h0);

    // autofire on P1 button 0
    io.autofire_en = 2'b01;
    send_key(24'h000014);
    cyc(3);
    ntrans = 0; last_t = -1; prev = io.joy_out[4];
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (io.joy_out[4] !== prev) begin
        if (last_t >= 0) check("af_period", 64'(i - last_t), 64'd4);
        last_t = i;
        ntrans++;
        prev = io.joy_out[4];
      end
    end
    check("af_toggles", 64'(ntrans >= 9), 64'd1);
    send_key(24'h00F014);
    cyc(3);
    check("af_key_release", io.joy_out[4], 1'b0);

    io.joy_in[4] = 1'b1;
    seen0 = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (!io.joy_out[4]) seen0 = 1'b1;
      else if (seen0) found = 1'b1;
    end
    check("af_rise_seen", found, 1'b1);
    io.joy_in[4] = 1'b0;
    cyc(1);
    check("af_release_next", io.joy_out[4], 1'b0);

    io.joy_in[20] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (io.joy_out[12]) cnt++;
    end
    check("af_p2_steady", 64'(cnt), 64'd10);
    io.joy_in = '0; io.autofire_en = '0;
    cyc(2);

    // coin pulse with re-presses during pulse and lockout
    ctr = '0;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0:  send_key(24'h00002E);
        2:  send_key(24'h00F02E);
        6:  io.joy_in[7] = 1'b1;
        7:  io.joy_in[7] = 1'b0;
        14: io.joy_in[7] = 1'b1;
        15: io.joy_in[7] = 1'b0;
        20: io.joy_in[7] = 1'b1;
        24: io.joy_in[7] = 1'b0;
        default: ;
      endcase
      cyc(1);
      ctr[i] = io.joy_out[7];
    end
    analyze(ctr, 40);
    check("coin_high_cycles", 64'(highs), 64'd16);
    check("coin_pulses", 64'(rises), 64'd2);
    check("coin_first_at", 64'(first_r), 64'd2);
    check("coin_second_at", 64'(second_r), 64'd21);
    cyc(12);

    // coin-then-start, mode flipped mid-sequence
    io.coinstart_mode = 1'b1;
    cyc(1);
    ctr = '0; str = '0;
    for (int i = 0; i < 45; i++) begin
      case (i)
        0:  send_key(24'h000005);
        2:  send_key(24'h00F005);
        12: io.coinstart_mode = 1'b0;
        default: ;
      endcase
      cyc(1);
      ctr[i] = io.joy_out[7];
      str[i] = io.joy_out[6];
    end
    analyze(ctr, 45);
    check("cs_coin_cycles", 64'(highs), 64'd8);
    check("cs_coin_first", 64'(first_r), 64'd2);
    analyze(str, 45);
    check("cs_start_cycles", 64'(highs), 64'd8);
    check("cs_start_first", 64'(first_r), 64'd23);
    check("cs_start_pulses", 64'(rises), 64'd1);

    // mode 0: start passes through, no coin
    send_key(24'h000005);
    cyc(2);
    check("start_pass", io.joy_out[7:6], 2'b01);
    send_key(24'h00F005);
    cyc(3);
    check("start_pass_release", io.joy_out, 16'h0);

    // reset during COIN
    io.joy_in[7] = 1'b1;
    cyc(4);
    check("coin_before_reset", io.joy_out[7], 1'b1);
    #1 reset = 1'b1;
    #1 check("reset_async", io.joy_out, 16'h0);
    io.joy_in = '0;
    cyc(2);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (io.joy_out[7]) cnt++;
    end
    check("idle_after_reset", 64'(cnt), 64'd0);

    // clr_keys
    send_key(24'h000029);
    cyc(2);
    check("space_press", io.joy_out[5], 1'b1);
    io.clr_keys = 1'b1;
    cyc(2);
    check("clr_release", io.joy_out[5], 1'b0);
    send_key(24'h000014);
    cyc(3);
    check("clr_drop_during", io.joy_out[4], 1'b0);
    io.clr_keys = 1'b0;
    cyc(3);
    check("clr_drop_after", io.joy_out, 16'h0);
    send_key(24'h000014);
    cyc(2);
    check("press_after_clr", io.joy_out, 16'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised input front end for arcade cores; sits between hps_io (ps2_key, joystick_N, status) and the game core's JOY inputs.
- Decodes PS/2 key events into per-player key state and merges it with MiSTer joysticks.
- Adds SOCD cleaning, per-player autofire, timed coin pulses, and an optional coin-then-start sequencer that replaces the hard-wired "coin = start" shortcut.

Parameters:
- NUM_PLAYERS, 2, player count (1..2).
- NUM_BTN, 2, action buttons per player (1..4).
- AUTOFIRE_HALF, 24'd1500000, cycles per autofire half-period (default gives 10 Hz at 30 MHz).
- COIN_PULSE_CYC, 24'd3000000, coin high time and post-pulse lockout, in cycles.
- START_DELAY_CYC, 24'd6000000, cycles from coin pulse end to start pulse in coin-start mode.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  65  hps_io key event; bit 64 toggles once per event.
- joy_in  in  16*NUM_PLAYERS  joystick_N concatenated, player 0 in the LSBs. Per player: [0]R [1]L [2]D [3]U [4+i] button i, [4+NUM_BTN] start, [5+NUM_BTN] coin.
- clr_keys  in  1  level; while high, all key state is released (held during ioctl_download).
- autofire_en  in  NUM_PLAYERS  per-player autofire enable, applied to button 0.
- coinstart_mode  in  1  1 = start request runs the coin-then-start sequence.
- joy_out  out  (6+NUM_BTN)*NUM_PLAYERS  per player: [0]R [1]L [2]D [3]U [4+i] button i, [4+NUM_BTN] start, [5+NUM_BTN] coin.

Behaviour:
- Reset: all registers and all joy_out bits are 0; FSMs go to IDLE; counters are 0.
- Key decode:
  - Register ps2_key[64]; an event is processed on the cycle that bit differs from its registered copy.
  - pressed = (ps2_key[15:8] != F0).
  - extended = pressed ? ([15:8] == E0) : ([23:16] == E0).
  - Any nonzero ps2_key[63:24] means the event is ignored.
  - Events update a key-state register bit per mapped key, using the scan-code table in the package.
  - P1: arrows (extended), Ctrl, Space, Alt, Shift, F1 start, 5 coin.
  - P2: R/D/F/G, A, S, Q, W, F2 start, 6 coin.
  - Unmapped codes are ignored.
- clr_keys: key state is forced to 0 every cycle while high; events arriving during that time are dropped.
- Merge: raw = key_state OR joystick bit, per player per bit.
- SOCD: L and R both raw-set gives both outputs 0; U and D both raw-set gives both outputs 0.
- Latency:
  - Joystick changes appear on joy_out one clock later (outputs are registered).
  - Key events appear two clocks after the ps2_key[64] toggle.
- Autofire:
  - One shared free-running counter wraps at AUTOFIRE_HALF-1 and toggles a phase bit on each wrap.
  - Button 0 output = raw AND (autofire_en[p] ? phase : 1).
  - Release clears the output on the next clock, regardless of phase.
- Coin, one FSM per player:
  - States: IDLE, COIN, GAP, WAIT, START.
  - IDLE: a rising edge of raw coin goes to COIN and loads the counter with COIN_PULSE_CYC-1.
  - COIN: coin out = 1 while the counter runs down; at 0 go to GAP and reload.
  - GAP: coin out = 0. At 0, go to WAIT if the sequence was started by start, else to IDLE.
  - Edges of coin arriving in COIN or GAP are ignored (no queueing).
- coinstart_mode = 1:
  - A rising edge of raw start in IDLE enters COIN and sets a seq flag.
  - WAIT lasts START_DELAY_CYC cycles, then goes to START.
  - START drives start out = 1 for COIN_PULSE_CYC cycles, then IDLE.
  - The raw start level is not passed to joy_out.
- coinstart_mode = 0: start out = raw start, directly.
- Changing coinstart_mode mid-sequence: the current sequence completes unchanged; the mode is sampled only in IDLE.
- Counters: 24-bit, saturating at 0; no wrap past 0.
- Simultaneous raw coin and start edges in IDLE: coin takes priority and seq is set only if coinstart_mode = 1.

Decomposition:
- Package input_map_pkg holds:
  - scan-code localparams per player and function;
  - joy bit-index localparams (R, L, D, U, BTN0, START_OFS, COIN_OFS);
  - the coin FSM state enum.
- Sub-module coin_start_seq holds the per-player FSM plus its 24-bit counter. It is instantiated NUM_PLAYERS times via generate.
- Key decode, SOCD, and autofire stay in the top block.

Test Plan:
- Joystick to output: joy_in P1 = 16'h0011 -> joy_out P1 R = 1, btn0 = 1 one clock later. Add bit1 (L) -> R = L = 0 (SOCD).
- PS/2 press/release: toggle ps2_key[64] with code E0 75 (Up) -> P1 U = 1 two clocks later. Send E0 F0 75 -> U = 0. A nonzero [63:24] event -> no change.
- Autofire: AUTOFIRE_HALF = 4, autofire_en = 1, Ctrl held for 40 cycles -> btn0 toggles every 4 cycles. Release -> 0 next clock.
- Coin pulse: COIN_PULSE_CYC = 8, press key 5 -> coin high exactly 8 cycles. A second press during the pulse or the 8-cycle gap -> no extra pulse.
- Coin-start: coinstart_mode = 1, START_DELAY_CYC = 5, F1 pressed -> coin 8 cycles, gap 8, wait 5, then start 8 cycles, then IDLE. Raw start is never visible.
- Reset and clr_keys: assert reset during COIN -> all outputs 0 immediately, FSM in IDLE. With Space held, assert clr_keys -> btn released; press events while clr_keys is high are dropped.
